// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, round count, Rcon and GF(2^8) S-box math.
// The S-boxes are derived from the field inverse plus the affine map.
package aes_pkg;

    typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL, DONE} aes_state_e;

    localparam int NR = 10;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = x15;
        for (int i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

endpackage

// File: rtl/aes_inv_core_key_step.sv
// Combinational AES-128 key schedule step, forward (rk_i -> rk_i+1) or
// inverse (rk_i -> rk_i-1); both directions share one SubWord.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk_in,
    input  logic         inverse,
    input  logic [7:0]   rcon_in,
    output logic [127:0] rk_out
);

    logic [31:0] w0, w1, w2, w3, p3, sw, t;

    always_comb begin
        {w0, w1, w2, w3} = rk_in;
        // inverse direction needs the previous key's last word first
        p3 = w3 ^ w2;
        sw = inverse ? p3 : w3;
        t  = {sbox(sw[23:16]), sbox(sw[15:8]), sbox(sw[7:0]), sbox(sw[31:24])}
             ^ {rcon_in, 24'h000000};
        if (inverse) begin
            rk_out = {w0 ^ t, w1 ^ w0, w2 ^ w1, p3};
        end else begin
            rk_out[127:96] = w0 ^ t;
            rk_out[95:64]  = w1 ^ w0 ^ t;
            rk_out[63:32]  = w2 ^ w1 ^ w0 ^ t;
            rk_out[31:0]   = w3 ^ w2 ^ w1 ^ w0 ^ t;
        end
    end

endmodule

// File: rtl/aes_inv_core.sv
// Iterative AES-128 decryptor: expand key forward to rk10, then run rounds while
// stepping the key backwards. Optional last-key cache: AES_KEY_CACHE_EN.
module aes_inv_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [127:0] key,
    input  logic [127:0] ciphertext,
    output logic         done,
    output logic [127:0] plaintext
);

    aes_state_e   state_q, state_d;
    logic [3:0]   cnt_q;
    logic [127:0] rk_q, st_q, rk_nxt;
    logic [127:0] isr, isb, ark, imc;
    logic [7:0]   a0, a1, a2, a3;
    logic         ks_inv, hit;

    assign ks_inv = (state_q != KEXP);

    aes_key_step u_key_step (
        .rk_in   (rk_q),
        .inverse (ks_inv),
        .rcon_in (rcon(ks_inv ? cnt_q : cnt_q + 4'd1)),
        .rk_out  (rk_nxt)
    );

`ifdef AES_KEY_CACHE_EN
    logic [127:0] ck_key, ck_rk10;
    logic         ck_vld;

    assign hit = ck_vld && (key == ck_key);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ck_key  <= '0;
            ck_rk10 <= '0;
            ck_vld  <= 1'b0;
        end else if (load) begin
            if (!hit) begin
                ck_key <= key;
                ck_vld <= 1'b0;
            end
        end else if (state_q == KEXP && cnt_q == 4'(NR - 1)) begin
            ck_rk10 <= rk_nxt;
            ck_vld  <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = hit ? INIT : KEXP;
        end else begin
            case (state_q)
                KEXP:    if (cnt_q == 4'(NR - 1)) state_d = INIT;
                INIT:    state_d = ROUND;
                ROUND:   if (cnt_q == 4'd1) state_d = FINAL;
                FINAL:   state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        isr = '0;
        isb = '0;
        imc = '0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                isr[127-8*(4*c+r) -: 8] = st_q[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        for (int b = 0; b < 16; b++) isb[127-8*b -: 8] = inv_sbox(isr[127-8*b -: 8]);
        ark = isb ^ rk_q;
        for (int c = 0; c < 4; c++) begin
            a0 = ark[127-32*c -: 8];
            a1 = ark[119-32*c -: 8];
            a2 = ark[111-32*c -: 8];
            a3 = ark[103-32*c -: 8];
            imc[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            imc[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            imc[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            imc[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
    end

    // st_q holds the raw ciphertext until INIT folds in rk10
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rk_q    <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                st_q <= ciphertext;
`ifdef AES_KEY_CACHE_EN
                rk_q  <= hit ? ck_rk10 : key;
                cnt_q <= hit ? 4'(NR) : 4'd0;
`else
                rk_q  <= key;
                cnt_q <= 4'd0;
`endif
            end else begin
                case (state_q)
                    KEXP: begin
                        rk_q  <= rk_nxt;
                        cnt_q <= cnt_q + 4'd1;
                    end
                    INIT: begin
                        st_q  <= st_q ^ rk_q;
                        rk_q  <= rk_nxt;
                        cnt_q <= cnt_q - 4'd1;
                    end
                    ROUND: begin
                        st_q  <= imc;
                        rk_q  <= rk_nxt;
                        cnt_q <= cnt_q - 4'd1;
                    end
                    FINAL:   st_q <= ark;
                    default: ;
                endcase
            end
        end
    end

    assign done      = (state_q == DONE);
    assign plaintext = done ? st_q : '0;

endmodule

// File: doc/aes_inv_core.md
AES_INV_CORE -- requirements
Module: aes_inv_core

Interface
REQ-001 No parameters; AES-128 only (Nk=4, Nb=4, Nr=10) shall be fixed.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 load  input  1  sampled high at a rising edge: capture key and ciphertext, start decryption.
REQ-005 key  input  128  AES cipher key (not pre-inverted), byte packing as FIPS-197: [127:120] = S0,0, word w[0] = [127:96].
REQ-006 ciphertext  input  128  block to decrypt, same packing as key.
REQ-007 done  output  1  high while plaintext is valid.
REQ-008 plaintext  output  128  decrypted block, same packing.

Function
REQ-009 States shall be IDLE, KEXP, INIT, ROUND, FINAL, DONE.
REQ-010 load high at edge E0 shall register key and ciphertext, clear the round counter, and enter KEXP, from any state.
REQ-011 KEXP shall run forward key expansion one round key per cycle: rk1..rk10 at edges E1..E10, then go to INIT.
REQ-012 INIT (E11) shall set state = ciphertext XOR rk10, step key inversely to rk9, and go to ROUND.
REQ-013 ROUND shall run 9 cycles (E12..E20), round r = 9 down to 1, each cycle: InvShiftRows, InvSubBytes, AddRoundKey(rk_r), InvMixColumns, with key stepped inversely to rk_(r-1).
REQ-014 FINAL (E21) shall run InvShiftRows, InvSubBytes, AddRoundKey(rk0) with no InvMixColumns, then go to DONE.
REQ-015 done shall rise after E21 (21 cycles after load) and stay high in DONE until the next load or reset.
REQ-016 plaintext shall be 0 whenever done is low, and shall hold the state register whenever done is high.
REQ-017 load held high for several cycles shall keep restarting at KEXP count 0; latency counts from the last edge at which load was high.
REQ-018 load during KEXP/INIT/ROUND/FINAL shall abort the operation with no partial output, and done shall stay low.
REQ-019 load in DONE shall drop done on the same edge.
REQ-020 Inverse key step: w[i-4] = w[i] XOR w[i-1] for the three non-first words, and w[0] shall use SubWord(RotWord(w[3]_prev)) XOR Rcon.
REQ-021 Rcon shall be indexed by the round counter; all arithmetic shall be GF(2^8) with polynomial 0x11B, and the counter shall be 4 bits and never wrap.

Reset
REQ-022 While reset is low: state = IDLE, done = 0, plaintext = 0, counters and key/state registers = 0, with no dependence on clk.
REQ-023 Reset asserted mid-operation shall discard the operation; after release the block shall stay IDLE until load.

Configuration
REQ-024 Macro AES_KEY_CACHE_EN, when defined, shall keep a copy of the last cipher key and its rk10 plus a valid bit cleared by reset.
REQ-025 With AES_KEY_CACHE_EN defined, a load whose key equals the cached key with valid = 1 shall skip KEXP: INIT at E1, done after E11.
REQ-026 With AES_KEY_CACHE_EN defined, a cache miss shall behave per REQ-011 and shall update the cache at the end of KEXP.
REQ-027 Without AES_KEY_CACHE_EN, the cache registers shall not exist and latency shall always be 21 cycles.

Structure
REQ-028 Package aes_pkg shall hold the FSM state enum, constant NR = 10, the Rcon table, and the forward and inverse S-box functions.
REQ-029 Sub-module aes_key_step shall be purely combinational: one round key in, direction and Rcon in, next or previous round key out, instanced once.
REQ-030 The InvShiftRows/InvSubBytes/InvMixColumns datapath shall be combinational between the state register's output and its input.

Verification
REQ-031 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, done after exactly 21 cycles.
REQ-032 FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734.
REQ-033 Reload at cycle 15 of the C.1 run with the App.B vector -> done low until 21 cycles after the reload, then App.B plaintext.
REQ-034 Drive reset low at cycle 8 -> done = 0 and plaintext = 0 immediately; block stays IDLE until the next load.
REQ-035 With AES_KEY_CACHE_EN, run C.1 twice back-to-back with the same key -> second done after 11 cycles with the same plaintext; a different key -> 21 cycles.
REQ-036 Loopback: random key and pt encrypted by aes_core, result fed to aes_inv_core -> original pt, over 1000 vectors.
